calc_operand_regfile: RTL and testbench
=======================================

// Module: calc_operand_regfile
// PURPOSE
//  Parametrised operand register file for the calculator datapath: DEPTH entries of DATA_W bits.
//  Filled in stack order by the key-entry path (push / delete-last) and patched by random-access writes.
//  NUM_RD independent combinational read ports feed the ALU and display.
//  Tracks fill level, flags full/empty, and records protocol errors in a sticky flag.
// PARAMETERS
//  DATA_W  8  entry width in bits
//  DEPTH   6  number of entries, >=2
//  NUM_RD  3  number of read ports, >=1
//  ADDR_W  $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               reset, synchronous, active-high
//  clr        in   1               synchronous clear of all entries, count and err
//  push       in   1               append push_data at index count
//  push_data  in   DATA_W          data for push
//  del        in   1               delete last entry (index count-1), zeroing it
//  wr_en      in   1               random-access write enable
//  wr_addr    in   ADDR_W          random-access write index
//  wr_data    in   DATA_W          random-access write data
//  rd_addr    in   NUM_RD*ADDR_W   packed read indices, port k at [k*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W   packed read data, port k at [k*DATA_W +: DATA_W]
//  count      out  ADDR_W+1        number of valid entries, 0..DEPTH
//  full       out  1               count == DEPTH
//  empty      out  1               count == 0
//  err        out  1               sticky error flag
// BEHAVIOUR
//  Reset: all entries 0; count=0; err=0; so full=0, empty=1, rd_data all 0. rst overrides every other input.
//  Priority per cycle: rst > clr > {push, del, wr_en}. clr has the same effect as rst.
//  Reads are combinational from the array. A write is visible on rd_data the cycle after its edge (no bypass).
//  rd_addr >= DEPTH returns 0. Reading an index >= count returns the stored value (no masking).
//  push only (count<DEPTH): entry[count] <= push_data; count+1.
//  push only when full: no write, count held, err <= 1.
//  del only (count>0): entry[count-1] <= 0; count-1.
//  del only when empty: no change, err <= 1.
//  push+del, count>0: replace top. entry[count-1] <= push_data; count held; no error even when full.
//  push+del, count==0: acts as push alone.
//  wr_en, wr_addr<DEPTH: entry[wr_addr] <= wr_data; count unchanged, including when wr_addr >= count.
//  wr_en, wr_addr>=DEPTH: write ignored, err <= 1.
//  wr_en together with push/del: both take effect unless they target the same index. In that case push/del wins and wr_en is dropped, with no error.
//  full, empty: combinational from count.
//  err: cleared only by rst or clr. When several error causes occur in one cycle, err is simply set.
// STRUCTURE
//  Shared package calc_pkg: CALC_DATA_W=8 and CALC_DEPTH=6 defaults, plus typedef calc_data_t.
//  One sub-module, calc_rf_rdmux: a single read port (index -> data, 0 when out of range), instantiated NUM_RD times in a generate loop.
//  Storage array, count register and err register are kept in this module.
// TESTING
//  1. rst, then push 0x11,0x22,0x33 -> count=3, rd ports (0,1,2) = 0x11,0x22,0x33, empty=0. Next del -> count=2 and entry[2]=0.
//  2. Push 6 values, then a 7th push 0xAA -> full=1, count=6, entry[5] unchanged, err=1. Then clr -> all entries 0, count=0, err=0.
//  3. count=2, push+del with push_data 0x5C -> entry[1]=0x5C, count=2, err=0. On empty, push+del 0x07 -> entry[0]=0x07, count=1.
//  4. del when empty -> count stays 0, err=1. wr_en with wr_addr=7 (DEPTH=6) -> array unchanged, err=1.
//  5. count=3, wr_en addr=1 data 0x99 while push 0x44 -> entry[1]=0x99, entry[3]=0x44, count=4.
//     Then wr_en addr=3 data 0xFF with del -> entry[3]=0, count=3, err=0.
//  6. rst asserted together with push, wr_en and clr -> all entries 0, count=0, err=0.
//     Repeat with DATA_W=16, DEPTH=8, NUM_RD=4: push 8 -> full, and all 4 ports read correct data.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator datapath defaults and the operand data type.
package calc_pkg;
    localparam int CALC_DATA_W = 8;
    localparam int CALC_DEPTH  = 6;

    typedef logic [CALC_DATA_W-1:0] calc_data_t;
endpackage

// File: rtl/calc_rf_rdmux.sv
// One combinational read port of the operand register file: index -> entry, zero when the index is out of range.
module calc_rf_rdmux #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < DEPTH_CNT) begin
            rd_data = mem_flat[rd_addr*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/calc_operand_regfile.sv
// Operand register file: stack-order fill (push/del), random-access patch writes, NUM_RD combinational reads.
// Updates land on the clock edge; reads are not bypassed. Protocol misuse sets a sticky err until rst/clr.
module calc_operand_regfile
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int DEPTH  = CALC_DEPTH,
    parameter int NUM_RD = 3,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     del,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];
    logic [ADDR_W:0]         count_q, count_d, count_m1;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       push_idx, top_idx;
    logic [DEPTH*DATA_W-1:0] mem_flat;

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        err_d    = err_q;
        count_m1 = count_q - 1'b1;
        push_idx = count_q[ADDR_W-1:0];
        top_idx  = count_m1[ADDR_W-1:0];
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            // Random-access write first so a push/del to the same index overrides it.
            if (wr_en) begin
                if ({1'b0, wr_addr} < DEPTH_CNT) begin
                    mem_d[wr_addr] = wr_data;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (push && del && (count_q != '0)) begin
                mem_d[top_idx] = push_data;
            end else if (push) begin
                if (count_q < DEPTH_CNT) begin
                    mem_d[push_idx] = push_data;
                    count_d         = count_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (del) begin
                if (count_q != '0) begin
                    mem_d[top_idx] = '0;
                    count_d        = count_m1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign err   = err_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        calc_rf_rdmux #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rdmux (
            .mem_flat (mem_flat),
            .rd_addr  (rd_addr[g*ADDR_W +: ADDR_W]),
            .rd_data  (rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_calc_operand_regfile.sv
// Randomized and directed check of calc_operand_regfile against a stack/array reference model,
// plus a directed fill of a wider 16-bit, 8-deep, 4-port configuration.
module tb_calc_operand_regfile;
    import calc_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: DATA_W=8, DEPTH=6, NUM_RD=3, ADDR_W=3
    logic        rst, clr, push, del, wr_en;
    calc_data_t  push_data, wr_data;
    logic [2:0]  wr_addr;
    logic [8:0]  rd_addr;
    logic [23:0] rd_data;
    logic [3:0]  count;
    logic        full, empty, err;

    calc_operand_regfile u_dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .push_data(push_data), .del(del),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .count(count), .full(full), .empty(empty), .err(err)
    );

    // Wide configuration: DATA_W=16, DEPTH=8, NUM_RD=4, ADDR_W=3
    logic        rst2, clr2, push2, del2, wr_en2;
    logic [15:0] push_data2, wr_data2;
    logic [2:0]  wr_addr2;
    logic [11:0] rd_addr2;
    logic [63:0] rd_data2;
    logic [3:0]  count2;
    logic        full2, empty2, err2;

    calc_operand_regfile #(.DATA_W(16), .DEPTH(8), .NUM_RD(4)) u_dut16 (
        .clk(clk), .rst(rst2), .clr(clr2), .push(push2), .push_data(push_data2), .del(del2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .count(count2), .full(full2), .empty(empty2), .err(err2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a stack of up to 6 operands with a sticky error bit.
    int mdl_mem [6];
    int mdl_cnt;
    bit mdl_err;

    function automatic void model_step(bit r, bit c, bit p, int pd, bit d, bit w, int wa, int wd);
        int tgt;
        int val;
        if (r || c) begin
            foreach (mdl_mem[i]) mdl_mem[i] = 0;
            mdl_cnt = 0;
            mdl_err = 0;
            return;
        end
        tgt = -1;
        val = 0;
        if (p && d && mdl_cnt > 0) begin
            tgt = mdl_cnt - 1; val = pd;
        end else if (p) begin
            if (mdl_cnt < 6) begin tgt = mdl_cnt; val = pd; mdl_cnt++; end
            else mdl_err = 1;
        end else if (d) begin
            if (mdl_cnt > 0) begin tgt = mdl_cnt - 1; val = 0; mdl_cnt--; end
            else mdl_err = 1;
        end
        if (w) begin
            if (wa >= 6) mdl_err = 1;
            else if (wa != tgt) mdl_mem[wa] = wd;
        end
        if (tgt >= 0) mdl_mem[tgt] = val;
    endfunction

    task automatic check_state(input string tag);
        logic [2:0] a;
        int         e;
        check({tag, "_count"}, 64'(count), 64'(mdl_cnt));
        check({tag, "_full"},  64'(full),  64'(mdl_cnt == 6));
        check({tag, "_empty"}, 64'(empty), 64'(mdl_cnt == 0));
        check({tag, "_err"},   64'(err),   64'(mdl_err));
        // Sweep addresses 0..8 (wrapping at 3 bits), covering the out-of-range indices 6 and 7.
        for (int b = 0; b < 9; b += 3) begin
            for (int k = 0; k < 3; k++) begin
                a = 3'(b + k);
                rd_addr[k*3 +: 3] = a;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                a = 3'(b + k);
                e = (int'(a) < 6) ? mdl_mem[int'(a)] : 0;
                check($sformatf("%s_rd%0d_a%0d", tag, k, a), 64'(rd_data[k*8 +: 8]), 64'(e));
            end
        end
    endtask

    task automatic cyc(input string tag, input bit r, input bit c, input bit p, input int pd,
                       input bit d, input bit w, input int wa, input int wd);
        @(negedge clk);
        rst = r; clr = c; push = p; push_data = 8'(pd); del = d;
        wr_en = w; wr_addr = 3'(wa); wr_data = 8'(wd);
        @(posedge clk);
        model_step(r, c, p, pd, d, w, wa, wd);
        #1;
        check_state(tag);
    endtask

    task automatic push_v(input string tag, input int v);
        cyc(tag, 0, 0, 1, v, 0, 0, 0, 0);
    endtask

    task automatic cyc2(input bit r, input bit p, input int pd);
        @(negedge clk);
        rst2 = r; clr2 = 0; push2 = p; push_data2 = 16'(pd); del2 = 0;
        wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; clr = 0; push = 0; push_data = '0; del = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_addr = '0;
        rst2 = 1; clr2 = 0; push2 = 0; push_data2 = '0; del2 = 0; wr_en2 = 0; wr_addr2 = '0;
        wr_data2 = '0; rd_addr2 = '0;
        foreach (mdl_mem[i]) mdl_mem[i] = 0;
        mdl_cnt = 0;
        mdl_err = 0;

        // Reset state
        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);

        // Stack fill, then delete-last zeroes the vacated entry
        push_v("t1_p0", 8'h11);
        push_v("t1_p1", 8'h22);
        push_v("t1_p2", 8'h33);
        check("t1_count3", 64'(count), 64'd3);
        cyc("t1_del", 0, 0, 0, 0, 1, 0, 0, 0);
        check("t1_count2", 64'(count), 64'd2);

        // Overfill raises err and leaves the top entry alone; clr wipes everything
        cyc("t2_rst", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) push_v($sformatf("t2_p%0d", i), 8'h60 + i);
        push_v("t2_over", 8'hAA);
        check("t2_full", 64'(full), 64'd1);
        check("t2_err",  64'(err),  64'd1);
        cyc("t2_clr", 0, 1, 0, 0, 0, 0, 0, 0);

        // Replace-top and push+del on empty
        push_v("t3_p0", 8'h01);
        push_v("t3_p1", 8'h02);
        cyc("t3_repl", 0, 0, 1, 8'h5C, 1, 0, 0, 0);
        cyc("t3_clr", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t3_pd_empty", 0, 0, 1, 8'h07, 1, 0, 0, 0);
        check("t3_count1", 64'(count), 64'd1);

        // Error cases: del when empty, write beyond DEPTH
        cyc("t4_clr", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t4_del_empty", 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("t4_clr2", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t4_wr7", 0, 0, 0, 0, 0, 1, 7, 8'h5A);
        check("t4_err", 64'(err), 64'd1);

        // Concurrent random-access write with push/del, including a same-index collision
        cyc("t5_clr", 0, 1, 0, 0, 0, 0, 0, 0);
        push_v("t5_p0", 8'hA0);
        push_v("t5_p1", 8'hA1);
        push_v("t5_p2", 8'hA2);
        cyc("t5_wr_push", 0, 0, 1, 8'h44, 0, 1, 1, 8'h99);
        cyc("t5_wr_del",  0, 0, 0, 0, 1, 1, 3, 8'hFF);
        check("t5_err0", 64'(err), 64'd0);
        cyc("t5_wr_hi", 0, 0, 0, 0, 0, 1, 5, 8'h3C);
        check("t5_count3", 64'(count), 64'd3);

        // rst overrides everything driven alongside it
        cyc("t6_rst_all", 1, 1, 1, 8'hEE, 0, 1, 2, 8'hDD);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit r, c, p, d, w;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 3);
            p = ($urandom_range(0, 99) < 45);
            d = ($urandom_range(0, 99) < 30);
            w = ($urandom_range(0, 99) < 35);
            cyc($sformatf("rnd%0d", n), r, c, p, $urandom_range(0, 255), d, w,
                $urandom_range(0, 7), $urandom_range(0, 255));
        end

        // Wide configuration: fill 8, read all through 4 ports, then overflow
        cyc2(1, 0, 0);
        check("w_reset_empty", 64'(empty2), 64'd1);
        check("w_reset_count", 64'(count2), 64'd0);
        for (int i = 0; i < 8; i++) cyc2(0, 1, 16'h1000 + i * 16'h0111);
        check("w_full",  64'(full2),  64'd1);
        check("w_count", 64'(count2), 64'd8);
        check("w_err0",  64'(err2),   64'd0);
        for (int b = 0; b < 8; b += 4) begin
            for (int k = 0; k < 4; k++) rd_addr2[k*3 +: 3] = 3'(b + k);
            #1;
            for (int k = 0; k < 4; k++)
                check($sformatf("w_rd%0d_a%0d", k, b + k), 64'(rd_data2[k*16 +: 16]),
                      64'(16'h1000 + (b + k) * 16'h0111));
        end
        cyc2(0, 1, 16'hBEEF);
        check("w_over_err",   64'(err2),   64'd1);
        check("w_over_count", 64'(count2), 64'd8);
        rd_addr2[0 +: 3] = 3'd7;
        #1;
        check("w_over_top", 64'(rd_data2[15:0]), 64'(16'h1000 + 7 * 16'h0111));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
